shift_sequencer: RTL and testbench

Multi-bit shift controller that wraps the 1-bit registered shifter stage of the 16-bit ALU. It accepts an operand, a shift amount (0–15), a direction and a fill mode. It then iterates: it drives its working value into the shifter, captures the shifter's registered left/right outputs, and applies fill-bit correction for rotate and arithmetic modes. The final result is presented to the ALU result mux with a one-cycle `done` pulse.

---
 rtl/shift_sequencer.sv | 123 ++++++++++++
 tb/tb_shift_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// Multi-step shift controller around the ALU's registered 1-bit shifter stage.
// Each bit step takes two cycles: DRIVE presents cur, CAPTURE folds the shifter output back in.
module shift_sequencer #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] operand,
    input  logic [AMT_W-1:0] amount,
    input  logic             dir,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] shA,
    input  logic [WIDTH-1:0] shLeftIn,
    input  logic [WIDTH-1:0] shRightIn,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam logic [1:0] MODE_ROTATE = 2'b01;
    localparam logic [1:0] MODE_ARITH  = 2'b10;
    localparam logic       DIR_RIGHT   = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } stateT;

    stateT            state;
    stateT            stateNext;
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] curNext;
    logic [AMT_W-1:0] cnt;
    logic [AMT_W-1:0] cntNext;
    logic             dirLat;
    logic             dirNext;
    logic [1:0]       modeLat;
    logic [1:0]       modeNext;

    logic [WIDTH-1:0] stepVal;
    logic [AMT_W-1:0] cntDec;

    assign cntDec = cnt - {{(AMT_W-1){1'b0}}, 1'b1};

    // The shifter always fills with zero; rotate and arithmetic right patch the vacated bit.
    always_comb begin
        if (dirLat == DIR_RIGHT) begin
            stepVal = shRightIn;
            if (modeLat == MODE_ROTATE) begin
                stepVal[WIDTH-1] = cur[0];
            end else if (modeLat == MODE_ARITH) begin
                stepVal[WIDTH-1] = cur[WIDTH-1];
            end
        end else begin
            stepVal = shLeftIn;
            if (modeLat == MODE_ROTATE) begin
                stepVal[0] = cur[WIDTH-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cur     <= '0;
            cnt     <= '0;
            dirLat  <= 1'b0;
            modeLat <= 2'b00;
        end else begin
            state   <= stateNext;
            cur     <= curNext;
            cnt     <= cntNext;
            dirLat  <= dirNext;
            modeLat <= modeNext;
        end
    end

    always_comb begin
        stateNext = state;
        curNext   = cur;
        cntNext   = cnt;
        dirNext   = dirLat;
        modeNext  = modeLat;
        case (state)
            IDLE: begin
                if (start) begin
                    curNext   = operand;
                    cntNext   = amount;
                    dirNext   = dir;
                    modeNext  = mode;
                    stateNext = (amount == '0) ? DONE : DRIVE;
                end
            end
            DRIVE: begin
                stateNext = CAPTURE;
            end
            CAPTURE: begin
                curNext   = stepVal;
                cntNext   = cntDec;
                stateNext = (cntDec == '0) ? DONE : DRIVE;
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_comb begin
        busy = (state == DRIVE) || (state == CAPTURE);
        done = (state == DONE);
    end

    assign shA    = cur;
    assign result = cur;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: models the registered 1-bit shifter and checks
// results and cycle timing against a direct arithmetic model of each shift mode.
module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] operand;
    logic [3:0]  amount;
    logic        dir;
    logic [1:0]  mode;
    logic [15:0] shA;
    logic [15:0] shLeftIn;
    logic [15:0] shRightIn;
    logic        busy;
    logic        done;
    logic [15:0] result;

    int nVec = 0;
    int nErr = 0;

    always #5 clk = ~clk;

    shift_sequencer #(.WIDTH(16), .AMT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .operand   (operand),
        .amount    (amount),
        .dir       (dir),
        .mode      (mode),
        .shA       (shA),
        .shLeftIn  (shLeftIn),
        .shRightIn (shRightIn),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    // Registered, unreset 1-bit shifter stage (zero fill both ways).
    always @(posedge clk) begin
        shLeftIn  <= shA << 1;
        shRightIn <= shA >> 1;
    end

    task automatic check(input string name, input int act, input int exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] refShift(input logic [15:0] op, input int n,
                                             input logic d, input logic [1:0] m);
        logic [31:0] dbl;
        logic [31:0] tmp;
        logic signed [15:0] sop;
        dbl = {op, op};
        sop = op;
        if (m == 2'b01) begin
            if (d == 1'b0) begin
                tmp = dbl << n;
                return tmp[31:16];
            end else begin
                tmp = dbl >> n;
                return tmp[15:0];
            end
        end
        if (d == 1'b0) return op << n;
        if (m == 2'b10) return 16'(sop >>> n);
        return op >> n;
    endfunction

    // Launches one request from a negedge; returns the edge index (relative to the
    // accept edge E0) after which done was observed, or -1 on timeout.
    task automatic runOp(input logic [15:0] op, input logic [3:0] amt, input logic d,
                         input logic [1:0] m, output logic [15:0] res, output int lat,
                         output int busyCnt, output int doneCnt);
        operand = op;
        amount  = amt;
        dir     = d;
        mode    = m;
        start   = 1'b1;
        lat     = -1;
        busyCnt = 0;
        doneCnt = 0;
        res     = 16'h0;
        for (int k = 0; k <= 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 0) begin
                start   = 1'b0;
                operand = 16'($urandom);
                amount  = 4'($urandom);
                dir     = 1'($urandom);
                mode    = 2'($urandom);
            end
            if (busy) busyCnt++;
            if (done) begin
                doneCnt++;
                if (lat < 0) begin
                    lat = k;
                    res = result;
                end
            end
            if (lat >= 0 && k >= lat + 2) break;
        end
        $display("op %h amt %0d dir %0d mode %0d -> result %h lat %0d busy %0d", op, amt, d, m,
                 res, lat, busyCnt);
    endtask

    typedef struct {
        logic [15:0] op;
        logic [3:0]  amt;
        logic        d;
        logic [1:0]  m;
        logic [15:0] expRes;
    } vecT;

    initial begin
        vecT         vecs [10];
        logic [15:0] res;
        logic [15:0] expRes;
        int          lat;
        int          busyCnt;
        int          doneCnt;
        int          expLat;
        int          n;

        vecs[0] = '{16'h8001, 4'd1,  1'b0, 2'b00, 16'h0002};
        vecs[1] = '{16'h8001, 4'd1,  1'b0, 2'b01, 16'h0003};
        vecs[2] = '{16'h1234, 4'd4,  1'b1, 2'b01, 16'h4123};
        vecs[3] = '{16'h8000, 4'd3,  1'b1, 2'b10, 16'hF000};
        vecs[4] = '{16'h4000, 4'd3,  1'b1, 2'b10, 16'h0800};
        vecs[5] = '{16'hBEEF, 4'd0,  1'b0, 2'b00, 16'hBEEF};
        vecs[6] = '{16'hFFFF, 4'd15, 1'b0, 2'b00, 16'h8000};
        vecs[7] = '{16'h00F0, 4'd4,  1'b1, 2'b11, 16'h000F};
        vecs[8] = '{16'h4001, 4'd1,  1'b0, 2'b10, 16'h8002};
        vecs[9] = '{16'h8421, 4'd15, 1'b1, 2'b01, 16'h0843};

        rst_n   = 1'b0;
        start   = 1'b0;
        operand = 16'h0;
        amount  = 4'h0;
        dir     = 1'b0;
        mode    = 2'b00;
        @(posedge clk);
        @(negedge clk);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_result", int'(result), 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table; amount 0 finishes in the cycle right after the accept edge.
        for (int i = 0; i < 10; i++) begin
            runOp(vecs[i].op, vecs[i].amt, vecs[i].d, vecs[i].m, res, lat, busyCnt, doneCnt);
            n = int'(vecs[i].amt);
            expLat = 2 * n;
            check("tbl_result", int'(res), int'(vecs[i].expRes));
            check("tbl_latency", lat, expLat);
            check("tbl_busy_cycles", busyCnt, expLat);
            check("tbl_done_pulses", doneCnt, 1);
            check("tbl_result_held", int'(result), int'(vecs[i].expRes));
        end

        // Randomized requests against the arithmetic model.
        for (int i = 0; i < 30; i++) begin
            logic [15:0] rop;
            logic [3:0]  ramt;
            logic        rd;
            logic [1:0]  rm;
            rop  = 16'($urandom);
            ramt = 4'($urandom_range(0, 15));
            rd   = 1'($urandom);
            rm   = 2'($urandom);
            expRes = refShift(rop, int'(ramt), rd, rm);
            runOp(rop, ramt, rd, rm, res, lat, busyCnt, doneCnt);
            check("rnd_result", int'(res), int'(expRes));
            check("rnd_latency", lat, 2 * int'(ramt));
            check("rnd_done_pulses", doneCnt, 1);
        end

        // A second start while busy (at E3) must be ignored.
        operand = 16'h00FF;
        amount  = 4'd2;
        dir     = 1'b0;
        mode    = 2'b00;
        start   = 1'b1;
        doneCnt = 0;
        res     = 16'h0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            @(negedge clk);
            start = (k == 2);
            if (k == 2) begin
                operand = 16'h1111;
                amount  = 4'd2;
            end
            if (done) begin
                doneCnt++;
                res = result;
            end
        end
        $display("protocol: second start ignored -> result %h done pulses %0d", res, doneCnt);
        check("proto_result", int'(res), 16'h03FC);
        check("proto_done_pulses", doneCnt, 1);
        check("proto_idle_busy", int'(busy), 0);

        // Asynchronous reset during CAPTURE of a 5-step shift.
        operand = 16'h0001;
        amount  = 4'd5;
        dir     = 1'b0;
        mode    = 2'b00;
        start   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #2;
        check("pre_reset_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("async_reset_busy", int'(busy), 0);
        check("async_reset_done", int'(done), 0);
        check("async_reset_result", int'(result), 0);
        @(negedge clk);
        rst_n = 1'b1;
        doneCnt = 0;
        busyCnt = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) doneCnt++;
            if (busy) busyCnt++;
        end
        $display("reset mid-op: done pulses after release %0d busy cycles %0d", doneCnt, busyCnt);
        check("reset_no_done", doneCnt, 0);
        check("reset_no_busy", busyCnt, 0);

        runOp(16'h0F0F, 4'd2, 1'b1, 2'b01, res, lat, busyCnt, doneCnt);
        check("post_reset_result", int'(res), 16'hC3C3);
        check("post_reset_latency", lat, 4);
        check("post_reset_done_pulses", doneCnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
